// File: rtl/serial_tx.sv
// serial_tx: parallel-load, MSB-first serializer with optional even-parity bit.
// A new word can be accepted while idle or during the last bit of a frame, so
// consecutive frames stream out with no idle gap.
module serial_tx #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned PARITY_EN = 0
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             Load_Valid,
   input  logic [WIDTH-1:0] Data_In,
   output logic             Load_Ready,
   output logic             Sdo,
   output logic             Sdo_Valid,
   output logic             Frame,
   output logic             Done
);

   localparam int unsigned FLEN = WIDTH + PARITY_EN;
   localparam int unsigned CW   = $clog2(FLEN + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             par;
   logic             last_bit;
   logic             accept;

   // Handshake: ready when idle or on the final frame bit, never during Clr.
   always_comb begin
      cnt_nxt    = cnt + CW'(1);
      last_bit   = (state == SHIFT) && (cnt == CW'(FLEN - 1));
      Load_Ready = !Clr && ((state == IDLE) || last_bit);
      accept     = Load_Valid && Load_Ready;
   end

   // Frame sequencer: cnt is the index of the bit currently on Sdo.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         par       <= 1'b0;
         Sdo       <= 1'b0;
         Sdo_Valid <= 1'b0;
         Frame     <= 1'b0;
         Done      <= 1'b0;
      end else if (accept) begin
         state     <= SHIFT;
         shreg     <= {Data_In[WIDTH-2:0], 1'b0};
         cnt       <= '0;
         par       <= Data_In[WIDTH-1];
         Sdo       <= Data_In[WIDTH-1];
         Sdo_Valid <= 1'b1;
         Frame     <= 1'b1;
         Done      <= 1'b0;
      end else if (state == SHIFT) begin
         if (last_bit) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            par       <= 1'b0;
            Sdo       <= 1'b0;
            Sdo_Valid <= 1'b0;
            Frame     <= 1'b0;
            Done      <= 1'b0;
         end else begin
            cnt   <= cnt_nxt;
            Frame <= 1'b0;
            Done  <= (cnt_nxt == CW'(FLEN - 1));
            if (cnt_nxt == CW'(WIDTH)) begin
               // Payload exhausted: par now holds the XOR of every payload bit.
               Sdo <= par;
            end else begin
               Sdo   <= shreg[WIDTH-1];
               shreg <= {shreg[WIDTH-2:0], 1'b0};
               par   <= par ^ shreg[WIDTH-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed checks of serial_tx in three configurations:
// unit 0 = WIDTH 8 no parity, unit 1 = WIDTH 8 with parity, unit 2 = WIDTH 2.
module tb_serial_tx;

   localparam int UW [3] = '{8, 8, 2};
   localparam int UP [3] = '{0, 1, 0};

   logic        clk;
   logic [2:0]  clr;
   logic [2:0]  lv;
   logic [2:0]  rdy;
   logic [2:0]  sdo;
   logic [2:0]  vld;
   logic [2:0]  frm;
   logic [2:0]  dn;
   logic [31:0] din [3];

   int compared   = 0;
   int mismatched = 0;

   serial_tx #(.WIDTH(8), .PARITY_EN(0)) u0 (
      .Clk(clk), .Clr(clr[0]), .Load_Valid(lv[0]), .Data_In(din[0][7:0]),
      .Load_Ready(rdy[0]), .Sdo(sdo[0]), .Sdo_Valid(vld[0]), .Frame(frm[0]), .Done(dn[0]));

   serial_tx #(.WIDTH(8), .PARITY_EN(1)) u1 (
      .Clk(clk), .Clr(clr[1]), .Load_Valid(lv[1]), .Data_In(din[1][7:0]),
      .Load_Ready(rdy[1]), .Sdo(sdo[1]), .Sdo_Valid(vld[1]), .Frame(frm[1]), .Done(dn[1]));

   serial_tx #(.WIDTH(2), .PARITY_EN(0)) u2 (
      .Clk(clk), .Clr(clr[2]), .Load_Valid(lv[2]), .Data_In(din[2][1:0]),
      .Load_Ready(rdy[2]), .Sdo(sdo[2]), .Sdo_Valid(vld[2]), .Frame(frm[2]), .Done(dn[2]));

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input int u, input int k, input logic b, input int fl);
      chk($sformatf("u%0d bit%0d sdo", u, k),   32'(sdo[u]), 32'(b));
      chk($sformatf("u%0d bit%0d valid", u, k), 32'(vld[u]), 32'd1);
      chk($sformatf("u%0d bit%0d frame", u, k), 32'(frm[u]), 32'(k == 1));
      chk($sformatf("u%0d bit%0d done", u, k),  32'(dn[u]),  32'(k == fl));
      chk($sformatf("u%0d bit%0d ready", u, k), 32'(rdy[u]), 32'(k == fl));
   endtask

   task automatic chk_idle(input int u, input string tag);
      chk($sformatf("u%0d %s sdo", u, tag),   32'(sdo[u]), 32'd0);
      chk($sformatf("u%0d %s valid", u, tag), 32'(vld[u]), 32'd0);
      chk($sformatf("u%0d %s frame", u, tag), 32'(frm[u]), 32'd0);
      chk($sformatf("u%0d %s done", u, tag),  32'(dn[u]),  32'd0);
      chk($sformatf("u%0d %s ready", u, tag), 32'(rdy[u]), 32'd1);
   endtask

   // Offer a word from idle, confirm ready, and take the accepting edge.
   task automatic start(input int u, input logic [31:0] d);
      lv[u]  = 1'b1;
      din[u] = d;
      #1;
      chk($sformatf("u%0d start ready", u), 32'(rdy[u]), 32'd1);
      step();
   endtask

   // Check a whole frame starting at its first bit. pat holds the expected
   // frame bits, first bit in position fl-1. hold keeps Load_Valid high with
   // junk data mid-frame; nd/nv is what is offered during the last bit.
   task automatic run_frame(input int u, input logic [31:0] pat, input bit hold,
                            input logic [31:0] nd, input bit nv);
      int fl;
      logic [31:0] mask;
      fl   = UW[u] + UP[u];
      mask = (32'd1 << UW[u]) - 32'd1;
      for (int k = 1; k <= fl; k++) begin
         chk_bit(u, k, pat[fl-k], fl);
         if (k < fl) begin
            lv[u]  = hold;
            din[u] = hold ? ($urandom & mask) : 32'd0;
         end else begin
            lv[u]  = nv;
            din[u] = nd;
         end
         step();
      end
   endtask

   initial begin
      clr = 3'b111;
      lv  = 3'b000;
      for (int i = 0; i < 3; i++) din[i] = 32'd0;

      // Reset state while Clr is held
      step();
      step();
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("u%0d rst sdo", u),   32'(sdo[u]), 32'd0);
         chk($sformatf("u%0d rst valid", u), 32'(vld[u]), 32'd0);
         chk($sformatf("u%0d rst frame", u), 32'(frm[u]), 32'd0);
         chk($sformatf("u%0d rst done", u),  32'(dn[u]),  32'd0);
         chk($sformatf("u%0d rst ready", u), 32'(rdy[u]), 32'd0);
      end
      clr = 3'b000;
      #1;
      for (int u = 0; u < 3; u++)
         chk($sformatf("u%0d post-rst ready", u), 32'(rdy[u]), 32'd1);

      // Single frame 0xA5 -> 1,0,1,0,0,1,0,1
      start(0, 32'hA5);
      run_frame(0, 32'b10100101, 1'b0, 32'd0, 1'b0);
      chk_idle(0, "after A5");

      // Back-to-back 0xFF then 0x00 accepted on the last bit
      start(0, 32'hFF);
      run_frame(0, 32'b11111111, 1'b0, 32'h00, 1'b1);
      run_frame(0, 32'b00000000, 1'b0, 32'd0, 1'b0);
      chk_idle(0, "after FF/00");

      // Clr on the 4th bit of 0xA5, with a simultaneous offer
      start(0, 32'hA5);
      for (int k = 1; k <= 3; k++) begin
         chk_bit(0, k, (k == 1 || k == 3) ? 1'b1 : 1'b0, 8);
         lv[0] = 1'b0;
         step();
      end
      chk_bit(0, 4, 1'b0, 8);
      clr[0] = 1'b1;
      lv[0]  = 1'b1;
      din[0] = 32'h3C;
      #1;
      chk("u0 clr ready", 32'(rdy[0]), 32'd0);
      step();
      chk("u0 abort sdo", 32'(sdo[0]), 32'd0);
      chk("u0 abort valid", 32'(vld[0]), 32'd0);
      chk("u0 abort frame", 32'(frm[0]), 32'd0);
      chk("u0 abort done", 32'(dn[0]), 32'd0);
      chk("u0 abort ready", 32'(rdy[0]), 32'd0);
      step();
      chk("u0 abort2 valid", 32'(vld[0]), 32'd0);
      chk("u0 abort2 done", 32'(dn[0]), 32'd0);
      clr[0] = 1'b0;
      lv[0]  = 1'b0;
      #1;
      chk("u0 after clr ready", 32'(rdy[0]), 32'd1);
      start(0, 32'h3C);
      run_frame(0, 32'b00111100, 1'b0, 32'd0, 1'b0);
      chk_idle(0, "after 3C");

      // Backpressure: Load_Valid held, Data_In churning mid-frame
      start(0, 32'h5A);
      run_frame(0, 32'b01011010, 1'b1, 32'hC3, 1'b1);
      run_frame(0, 32'b11000011, 1'b1, 32'h96, 1'b1);
      run_frame(0, 32'b10010110, 1'b0, 32'd0, 1'b0);
      chk_idle(0, "after backpressure");

      // Parity: 0x07 -> parity 1, 0x03 -> parity 0
      start(1, 32'h07);
      run_frame(1, 32'b000001111, 1'b0, 32'd0, 1'b0);
      chk_idle(1, "after 07");
      start(1, 32'h03);
      run_frame(1, 32'b000000110, 1'b0, 32'd0, 1'b0);
      chk_idle(1, "after 03");

      // WIDTH=2 corner
      start(2, 32'b10);
      run_frame(2, 32'b10, 1'b0, 32'd0, 1'b0);
      chk_idle(2, "after 10");
      start(2, 32'b01);
      run_frame(2, 32'b01, 1'b0, 32'b11, 1'b1);
      run_frame(2, 32'b11, 1'b0, 32'b10, 1'b1);
      run_frame(2, 32'b10, 1'b0, 32'd0, 1'b0);
      chk_idle(2, "after w2 stream");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
